// File: rtl/led_sequencer.sv
//------------------------------------------------------------------------------
// Module   : led_sequencer
// Purpose  : Four-LED pattern generator (off/blink/chase/bounce) at one of
//            four step rates, with a one-deep command buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_sequencer #(
    parameter int RATE0_CYCLES = 12500000,
    parameter int RATE1_CYCLES = 6250000,
    parameter int RATE2_CYCLES = 3125000,
    parameter int RATE3_CYCLES = 2500000,
    parameter int CNT_W        = 24
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Cmd_Valid,
    input  logic [1:0] i_Cmd_Mode,
    input  logic [1:0] i_Cmd_Rate,
    output logic       o_Cmd_Ready,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic       o_Tick
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    localparam logic [1:0] c_MODE_OFF    = 2'd0;
    localparam logic [1:0] c_MODE_BLINK  = 2'd1;
    localparam logic [1:0] c_MODE_CHASE  = 2'd2;
    localparam logic [1:0] c_MODE_BOUNCE = 2'd3;

    localparam logic [CNT_W-1:0] c_TERM0 = CNT_W'(RATE0_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TERM1 = CNT_W'(RATE1_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TERM2 = CNT_W'(RATE2_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TERM3 = CNT_W'(RATE3_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic [1:0]       r_rate;
    logic [1:0]       r_pend_mode;
    logic [1:0]       r_pend_rate;
    logic             r_from_run;
    logic [3:0]       r_led;
    logic             r_dir_up;
    logic             r_tick;
    logic             r_ready;

    logic [CNT_W-1:0] w_term;
    logic             w_at_term;
    logic             w_accept;
    logic [3:0]       w_step_led;
    logic             w_step_dir;
    logic [3:0]       w_init_led;

    always_comb begin
        w_term = c_TERM0;
        case (r_rate)
            2'd0:    w_term = c_TERM0;
            2'd1:    w_term = c_TERM1;
            2'd2:    w_term = c_TERM2;
            default: w_term = c_TERM3;
        endcase
    end

    assign w_at_term = (r_cnt == w_term);
    assign w_accept  = i_Cmd_Valid && r_ready;

    // Bounce reverses when the lit LED sits at either end of the row.
    always_comb begin
        w_step_led = r_led;
        w_step_dir = r_dir_up;
        case (r_mode)
            c_MODE_BLINK: w_step_led = ~r_led;
            c_MODE_CHASE: w_step_led = {r_led[2:0], r_led[3]};
            c_MODE_BOUNCE: begin
                if (r_dir_up && r_led[3]) begin
                    w_step_led = r_led >> 1;
                    w_step_dir = 1'b0;
                end else if (!r_dir_up && r_led[0]) begin
                    w_step_led = r_led << 1;
                    w_step_dir = 1'b1;
                end else if (r_dir_up) begin
                    w_step_led = r_led << 1;
                end else begin
                    w_step_led = r_led >> 1;
                end
            end
            default: w_step_led = r_led;
        endcase
    end

    always_comb begin
        w_init_led = 4'b0000;
        case (r_pend_mode)
            c_MODE_BLINK:  w_init_led = 4'b1111;
            c_MODE_CHASE:  w_init_led = 4'b0001;
            c_MODE_BOUNCE: w_init_led = 4'b0001;
            default:       w_init_led = 4'b0000;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mode      <= c_MODE_OFF;
            r_rate      <= 2'd0;
            r_pend_mode <= c_MODE_OFF;
            r_pend_rate <= 2'd0;
            r_from_run  <= 1'b0;
            r_led       <= 4'b0000;
            r_dir_up    <= 1'b1;
            r_tick      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pend_mode <= i_Cmd_Mode;
                        r_pend_rate <= i_Cmd_Rate;
                        r_from_run  <= 1'b0;
                        r_ready     <= 1'b0;
                        r_state     <= S_PEND;
                    end
                end
                S_RUN: begin
                    if (w_at_term) begin
                        r_cnt    <= '0;
                        r_tick   <= 1'b1;
                        r_led    <= w_step_led;
                        r_dir_up <= w_step_dir;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                    if (w_accept) begin
                        r_pend_mode <= i_Cmd_Mode;
                        r_pend_rate <= i_Cmd_Rate;
                        r_from_run  <= 1'b1;
                        r_ready     <= 1'b0;
                        r_state     <= S_PEND;
                    end
                end
                S_PEND: begin
                    // A command held over a running pattern waits for the step
                    // boundary so the old phase is never cut short.
                    if (!r_from_run || w_at_term) begin
                        r_mode   <= r_pend_mode;
                        r_rate   <= r_pend_rate;
                        r_cnt    <= '0;
                        r_led    <= w_init_led;
                        r_dir_up <= 1'b1;
                        r_ready  <= 1'b1;
                        r_state  <= (r_pend_mode == c_MODE_OFF) ? S_IDLE : S_RUN;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_Cmd_Ready = r_ready;
    assign o_Tick      = r_tick;
    assign o_LED_1     = r_led[0];
    assign o_LED_2     = r_led[1];
    assign o_LED_3     = r_led[2];
    assign o_LED_4     = r_led[3];

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_led_sequencer
// Purpose  : Scoreboarded bench for led_sequencer against a step-index model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_led_sequencer;

    localparam int R0 = 5;
    localparam int R1 = 4;
    localparam int R2 = 3;
    localparam int R3 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic [1:0] rate  = 2'd0;
    logic       ready, tick, l1, l2, l3, l4;

    led_sequencer #(
        .RATE0_CYCLES(R0), .RATE1_CYCLES(R1), .RATE2_CYCLES(R2),
        .RATE3_CYCLES(R3), .CNT_W(4)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Cmd_Valid(valid), .i_Cmd_Mode(mode),
        .i_Cmd_Rate(rate), .o_Cmd_Ready(ready), .o_LED_1(l1), .o_LED_2(l2),
        .o_LED_3(l3), .o_LED_4(l4), .o_Tick(tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected {ready, tick, led4..led1} for each cycle, one entry per edge.
    logic [5:0] exp_q[$];

    // Reference model: the pattern is a pure function of mode and step index.
    bit m_run, m_pend, m_from_run;
    int m_mode, m_rate, m_pmode, m_prate, m_cnt, m_phase;

    function automatic int period(input int r);
        case (r)
            0:       return R0;
            1:       return R1;
            2:       return R2;
            default: return R3;
        endcase
    endfunction

    function automatic logic [3:0] pattern(input int md, input int ph);
        int         bseq[6] = '{0, 1, 2, 3, 2, 1};
        logic [3:0] one = 4'b0001;
        case (md)
            1:       return (ph % 2 == 0) ? 4'hF : 4'h0;
            2:       return one << (ph % 4);
            3:       return one << bseq[ph % 6];
            default: return 4'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_from_run = 0;
        m_mode = 0; m_rate = 0; m_cnt = 0; m_phase = 0;
    endtask

    task automatic model_apply();
        m_mode  = m_pmode;
        m_rate  = m_prate;
        m_cnt   = 0;
        m_phase = 0;
        m_run   = (m_pmode != 0);
        m_pend  = 0;
    endtask

    always @(posedge clk) begin : model
        bit rdy, acc, tk;
        if (rst) begin
            model_reset();
            exp_q.push_back(6'b100000);
        end else begin
            rdy = !m_pend;
            acc = valid && rdy;
            tk  = 0;
            if (m_pend && !m_from_run) begin
                model_apply();
            end else if (m_run) begin
                if (m_cnt == period(m_rate) - 1) begin
                    m_cnt = 0;
                    if (m_pend) model_apply();
                    else begin
                        m_phase++;
                        tk = 1;
                    end
                end else begin
                    m_cnt++;
                end
            end
            if (acc) begin
                m_pend     = 1;
                m_from_run = m_run;
                m_pmode    = int'(mode);
                m_prate    = int'(rate);
            end
            exp_q.push_back({!m_pend, tk, m_run ? pattern(m_mode, m_phase) : 4'h0});
        end
    end

    always @(negedge clk) begin : monitor
        logic [5:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {ready, tick, l4, l3, l2, l1};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got ready=%b tick=%b led=%b expected ready=%b tick=%b led=%b",
                         $time, a[5], a[4], a[3:0], e[5], e[4], e[3:0]);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the command until the handshake completes, as a requester must.
    task automatic send(input logic [1:0] md, input logic [1:0] rt);
        bit done = 0;
        valid = 1'b1; mode = md; rate = rt;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        valid = 1'b0; mode = 2'($urandom); rate = 2'($urandom);
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout got no accept expected accept mode=%0d rate=%0d", md, rt);
        end
    endtask

    task automatic wait_tick();
        bit seen = 0;
        for (int i = 0; i < 32 && !seen; i++) begin
            @(negedge clk);
            seen = tick;
        end
        @(posedge clk);
        #1;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL tick_timeout got no tick expected tick");
        end
    endtask

    // Reset pulsed between edges; outputs must clear without a clock.
    task automatic async_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ready, tick, l4, l3, l2, l1} !== 6'b100000) begin
            errors++;
            $display("FAIL async_reset got %b expected 100000", {ready, tick, l4, l3, l2, l1});
        end
        model_reset();
        exp_q.delete();
        exp_q.push_back(6'b100000);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(2);

        send(2'd2, 2'd1);            // chase, tick every 4
        wait_cycles(20);
        send(2'd3, 2'd3);            // bounce, tick every cycle
        wait_cycles(12);
        send(2'd1, 2'd0);            // blink, 5-cycle steps
        wait_cycles(7);
        wait_tick();
        wait_cycles(1);
        send(2'd2, 2'd2);            // deferred to the next step boundary
        send(2'd3, 2'd1);            // held while not ready
        wait_cycles(20);
        send(2'd0, 2'd0);            // off at the next tick
        wait_cycles(12);
        send(2'd1, 2'd0);
        wait_cycles(3);
        send(2'd2, 2'd1);
        async_reset();               // pending command must be dropped
        wait_cycles(10);
        send(2'd2, 2'd2);
        wait_cycles(4);
        send(2'd2, 2'd2);            // identical command restarts phase
        wait_cycles(10);

        repeat (40) begin
            send(2'($urandom), 2'($urandom));
            wait_cycles($urandom_range(0, 15));
        end
        wait_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
